rr_arbiter8: RTL and testbench

Eight-requester round-robin arbiter that shares one resource, such as a shared bus or register-file write port, among up to eight clients. It issues a registered one-hot grant plus its 3-bit encoded index, so the index can drive the existing 3-to-8 select logic directly. Grants are held while the owner keeps requesting, with an optional hold limit that forces rotation when others are waiting. It sits between the requesting blocks and the shared datapath's select/enable lines.

---
 rtl/arb_pkg.sv | 11 +
 rtl/rr_pick8.sv | 37 +++
 rtl/rr_arbiter8.sv | 86 ++++++++
 tb/tb_rr_arbiter8.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the eight-client round-robin arbiter.
package arb_pkg;
    localparam int NREQ = 8;

    typedef logic [2:0] req_idx_t;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;
endpackage

// File: rtl/rr_pick8.sv
// Masked circular priority encoder: first eligible request at or after ptr, wrapping mod 8.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    input  logic [7:0] mask,
    output logic       any,
    output logic [2:0] idx,
    output logic [7:0] onehot
);
    logic [7:0] eligible;
    logic [7:0] rot;
    req_idx_t   offset;

    // mask bit set means that client is excluded from this pick
    assign eligible = req & ~mask;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            assign rot[gi] = eligible[req_idx_t'(ptr + req_idx_t'(gi))];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = req_idx_t'(i);
            end
        end
    end

    assign any    = |rot;
    assign idx    = ptr + offset;
    assign onehot = any ? (8'd1 << idx) : 8'd0;
endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot/encoded grant and
// an optional hold limit that forces rotation when other clients are waiting.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);
    localparam int HCW = (HOLD_MAX > 0) ? (($clog2(HOLD_MAX + 1) > 0) ? $clog2(HOLD_MAX + 1) : 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    arb_state_t     state_reg;
    logic [7:0]     gnt_reg;
    req_idx_t       idx_reg;
    logic           valid_reg;
    req_idx_t       ptr_reg;
    logic [HCW-1:0] hold_cnt_reg;

    logic       pick_any;
    req_idx_t   pick_idx;
    logic [7:0] pick_onehot;
    logic [7:0] pick_mask;
    logic       limit_hit;
    logic       owner_req;
    logic       take_new;

    // While granting, the owner is masked: a pick that succeeds is always
    // someone else, which is exactly what both release and timeout need.
    assign pick_mask = (state_reg == GRANT) ? gnt_reg : 8'd0;
    assign owner_req = req[idx_reg];
    assign limit_hit = (HOLD_MAX != 0) && (hold_cnt_reg == HOLD_LAST);

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .mask   (pick_mask),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        take_new = 1'b0;
        if (pick_any) begin
            take_new = (state_reg == IDLE) || !owner_req || limit_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            gnt_reg      <= 8'd0;
            idx_reg      <= '0;
            valid_reg    <= 1'b0;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
        end else if (take_new) begin
            state_reg    <= GRANT;
            gnt_reg      <= pick_onehot;
            idx_reg      <= pick_idx;
            valid_reg    <= 1'b1;
            ptr_reg      <= pick_idx + req_idx_t'(1);
            hold_cnt_reg <= '0;
        end else if (state_reg == GRANT && owner_req) begin
            if (hold_cnt_reg != HOLD_LAST) begin
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
        end else begin
            state_reg    <= IDLE;
            gnt_reg      <= 8'd0;
            idx_reg      <= '0;
            valid_reg    <= 1'b0;
            hold_cnt_reg <= '0;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_idx   = idx_reg;
    assign gnt_valid = valid_reg;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and randomized check of rr_arbiter8 (HOLD_MAX=4) against a behavioural round-robin model.
module tb_rr_arbiter8;
    localparam int HM = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int tests_run;
    int tests_failed;

    // model state: owner -1 means idle, held counts cycles granted so far
    int m_owner;
    int m_ptr;
    int m_held;

    rr_arbiter8 #(.HOLD_MAX(HM)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input logic [7:0] r, input logic rn);
        logic [7:0] cand;
        logic [7:0] others;
        int found;
        int c;
        if (!rn) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            return;
        end
        cand = r;
        if (m_owner >= 0) cand[m_owner] = 1'b0;
        others = cand;
        if (m_owner >= 0 && r[m_owner] && !(HM != 0 && m_held >= HM && others != 0)) begin
            if (m_held < HM) m_held++;
            return;
        end
        found = -1;
        for (int j = 0; j < 8; j++) begin
            c = (m_ptr + j) % 8;
            if (found < 0 && cand[c]) found = c;
        end
        if (found >= 0) begin
            m_owner = found;
            m_ptr   = (found + 1) % 8;
            m_held  = 1;
        end else begin
            m_owner = -1;
            m_held  = 0;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h (req=%h t=%0t)", tag, obs, exp, req, $time);
        end
    endtask

    // Drive one cycle: inputs applied on the falling edge, outputs checked on the next falling edge.
    task automatic step(input logic [7:0] r, input logic rn);
        logic [7:0] e_gnt;
        logic [7:0] e_idx;
        req     = r;
        reset_n = rn;
        @(posedge clk);
        model_edge(r, rn);
        @(negedge clk);
        e_gnt = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
        e_idx = (m_owner < 0) ? 8'd0 : 8'(m_owner);
        check("gnt", gnt, e_gnt);
        check("gnt_idx", {5'd0, gnt_idx}, e_idx);
        check("gnt_valid", {7'd0, gnt_valid}, {7'd0, m_owner >= 0});
        $display("[TB] t=%0t rst_n=%0b req=%h gnt=%h idx=%0d valid=%0b", $time, rn, r, gnt, gnt_idx, gnt_valid);
    endtask

    initial begin
        logic [7:0] r;
        tests_run    = 0;
        tests_failed = 0;
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        req     = 8'h00;
        reset_n = 1'b0;
        @(negedge clk);

        // reset with all requesting
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b0);

        // first grant, then release handover with no idle gap
        step(8'h05, 1'b1);
        check("first_grant", gnt, 8'h01);
        step(8'h04, 1'b1);
        check("handover", gnt, 8'h04);
        step(8'h00, 1'b1);

        // full rotation with every client requesting
        for (int i = 0; i < 36; i++) step(8'hFF, 1'b1);
        step(8'h00, 1'b1);

        // wrap: owner 6 times out, then 0 and 1 are served before 6 again
        step(8'h40, 1'b1);
        for (int i = 0; i < 14; i++) step(8'h43, 1'b1);
        step(8'h03, 1'b1);
        step(8'h00, 1'b1);

        // lone requester saturates the hold, then yields once another appears
        for (int i = 0; i < 10; i++) step(8'h08, 1'b1);
        check("lone_hold", gnt, 8'h08);
        step(8'h28, 1'b1);
        check("late_timeout", gnt, 8'h20);
        step(8'h00, 1'b1);

        // reset pulse mid-grant
        step(8'h10, 1'b1);
        step(8'h10, 1'b1);
        step(8'h10, 1'b0);
        check("reset_drop", gnt, 8'h00);
        step(8'h10, 1'b1);
        check("after_reset", gnt, 8'h10);

        // randomized traffic with sticky requests and occasional resets
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: r = 8'h00;
                1: r = 8'($urandom);
                2: r = r & 8'($urandom);
                3: r = r | (8'd1 << $urandom_range(0, 7));
                default: r = r;
            endcase
            step(r, ($urandom_range(0, 63) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
